// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: FSM encodings,
// stall bus layout and stop/go constants.
package md_sched_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] StallBus;

  localparam int EX_STALL = 3;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/md_sched_hilo_reg.sv
// HI/LO register pair. A unit result commits both halves; mthi/mtlo write one.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rdata
);

  logic [31:0] hi;
  logic [31:0] lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (res_we) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd_hi)      rdata = hi;
    else if (rd_lo) rdata = lo;
  end

endmodule

// File: rtl/md_sched.sv
// Sequencer for the shared iterative mult/div unit: start pulse, EX stall,
// timeout abort and HI/LO commit.
//
// state   | meaning
// MD_IDLE | no op in flight; a mult/div in EX raises stall and launches
// MD_BUSY | unit running; EX stalled until md_done or timeout
// MD_DONE | result committed; wait for EX to advance so the op is not reissued
module md_sched
  import md_sched_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        inst_div,
  input  logic        inst_divu,
  input  logic        inst_mult,
  input  logic        inst_multu,
  input  logic        inst_mthi,
  input  logic        inst_mtlo,
  input  logic        inst_mfhi,
  input  logic        inst_mflo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        md_start,
  output logic        md_is_div,
  output logic        md_signed,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        stallreq_ex,
  output logic [31:0] hilo_rdata,
  output logic        md_timeout
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  logic md_req;
  logic div0;
  logic launch;
  logic ex_go;
  logic res_we;
  logic unused_stall;

  assign md_req = inst_div | inst_divu | inst_mult | inst_multu;
  assign div0   = (inst_div | inst_divu) & (src_b == 32'd0);
  assign launch = (state == MD_IDLE) & md_req & ~div0;
  assign ex_go  = (stall[EX_STALL] == NoStop);
  assign res_we = (state == MD_BUSY) & md_done;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Depends only on state and op flags so the stall controller sees no loop.
  assign stallreq_ex = launch | (state == MD_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MD_IDLE;
      md_start   <= 1'b0;
      md_a       <= 32'd0;
      md_b       <= 32'd0;
      md_is_div  <= 1'b0;
      md_signed  <= 1'b0;
      md_timeout <= 1'b0;
      cnt        <= '0;
    end else begin
      md_start <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (launch) begin
            md_start  <= 1'b1;
            md_a      <= src_a;
            md_b      <= src_b;
            md_is_div <= inst_div | inst_divu;
            md_signed <= inst_div | inst_mult;
            cnt       <= '0;
            state     <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          cnt <= cnt + 1'b1;
          if (md_done) begin
            state <= MD_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            md_timeout <= 1'b1;
            state      <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (stall[EX_STALL] == NoStop) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  hilo_reg u_hilo (
    .clk    (clk),
    .rst    (rst),
    .res_we (res_we),
    .res_hi (md_hi),
    .res_lo (md_lo),
    .hi_we  (inst_mthi & ex_go),
    .lo_we  (inst_mtlo & ex_go),
    .wdata  (src_a),
    .rd_hi  (inst_mfhi),
    .rd_lo  (inst_mflo),
    .rdata  (hilo_rdata)
  );

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched with a stub iterative unit of programmable latency.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        inst_div, inst_divu, inst_mult, inst_multu;
  logic        inst_mthi, inst_mtlo, inst_mfhi, inst_mflo;
  logic [31:0] src_a, src_b;
  logic        md_start, md_is_div, md_signed;
  logic [31:0] md_a, md_b;
  logic        md_done;
  logic [31:0] md_hi, md_lo;
  logic        stallreq_ex;
  logic [31:0] hilo_rdata;
  logic        md_timeout;

  int checks   = 0;
  int failures = 0;

  // Stub unit: md_done lands in the stub_lat-th cycle, counting the start cycle as 1.
  int stub_lat = 0;
  int stub_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (md_start && stub_lat != 0) stub_cnt <= stub_lat - 1;
    else if (stub_cnt != 0)        stub_cnt <= stub_cnt - 1;
  end

  assign md_done = (stub_cnt == 1);

  md_sched dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .inst_div    (inst_div),
    .inst_divu   (inst_divu),
    .inst_mult   (inst_mult),
    .inst_multu  (inst_multu),
    .inst_mthi   (inst_mthi),
    .inst_mtlo   (inst_mtlo),
    .inst_mfhi   (inst_mfhi),
    .inst_mflo   (inst_mflo),
    .src_a       (src_a),
    .src_b       (src_b),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .md_signed   (md_signed),
    .md_a        (md_a),
    .md_b        (md_b),
    .md_done     (md_done),
    .md_hi       (md_hi),
    .md_lo       (md_lo),
    .stallreq_ex (stallreq_ex),
    .hilo_rdata  (hilo_rdata),
    .md_timeout  (md_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // op = {divu, div, multu, mult}. Holds the op in EX until stall drops,
  // keeps it there for `hold` extra cycles with stall[3]=1, then advances.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold,
                        output int scyc, output int starts, output int hold_bad);
    scyc = 0; starts = 0; hold_bad = 0;
    stub_lat = lat;
    {inst_divu, inst_div, inst_multu, inst_mult} = op;
    src_a = a;
    src_b = b;
    #1;
    for (int i = 0; i < 200 && stallreq_ex; i++) begin
      scyc++;
      if (md_start) starts++;
      @(posedge clk); #1;
    end
    if (stallreq_ex) chk("md_wait_bound", 32'd1, 32'd0);
    if (md_start) starts++;
    stall = 6'b001000;
    repeat (hold) begin
      @(posedge clk); #1;
      if (stallreq_ex || md_start) hold_bad++;
    end
    stall = 6'd0;
    @(posedge clk); #1;
    {inst_divu, inst_div, inst_multu, inst_mult} = 4'd0;
  endtask

  task automatic rd(input logic hi_sel, input string tag, input logic [31:0] exp);
    inst_mfhi = hi_sel;
    inst_mflo = ~hi_sel;
    #1;
    chk(tag, hilo_rdata, exp);
    @(posedge clk); #1;
    inst_mfhi = 1'b0;
    inst_mflo = 1'b0;
  endtask

  // A mult flag shows up as an immediate stall only when the FSM is idle.
  task automatic probe_idle(input string tag);
    inst_mult = 1'b1;
    src_b = 32'd1;
    #1;
    chk(tag, {31'd0, stallreq_ex}, 32'd1);
    inst_mult = 1'b0;
    #1;
  endtask

  int scyc, starts, hold_bad;

  initial begin
    rst = 1'b1; stall = 6'd0;
    {inst_div, inst_divu, inst_mult, inst_multu} = 4'd0;
    {inst_mthi, inst_mtlo, inst_mfhi, inst_mflo} = 4'd0;
    src_a = 32'd0; src_b = 32'd0; md_hi = 32'd0; md_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stallreq", {31'd0, stallreq_ex}, 32'd0);
    chk("rst_start",    {31'd0, md_start},    32'd0);
    chk("rst_timeout",  {31'd0, md_timeout},  32'd0);
    chk("rst_md_a",     md_a, 32'd0);
    chk("rst_md_b",     md_b, 32'd0);
    chk("rst_flags",    {30'd0, md_is_div, md_signed}, 32'd0);
    rst = 1'b0;
    rd(1'b1, "rst_hi", 32'd0);
    rd(1'b0, "rst_lo", 32'd0);

    // signed mult, 4-cycle unit
    md_hi = 32'hFFFF_FFFF; md_lo = 32'hFFFF_FFFA;
    run_md(4'b0001, 32'hFFFF_FFFE, 32'd3, 4, 0, scyc, starts, hold_bad);
    chk("mult_stall_cyc", scyc, 32'd5);
    chk("mult_starts",    starts, 32'd1);
    chk("mult_md_a",      md_a, 32'hFFFF_FFFE);
    chk("mult_md_b",      md_b, 32'd3);
    chk("mult_flags",     {30'd0, md_is_div, md_signed}, 32'b01);
    rd(1'b1, "mult_hi", 32'hFFFF_FFFF);
    rd(1'b0, "mult_lo", 32'hFFFF_FFFA);

    // divu 100/7, 33-cycle unit, held 3 extra cycles in DONE
    md_hi = 32'd2; md_lo = 32'd14;
    run_md(4'b1000, 32'd100, 32'd7, 33, 3, scyc, starts, hold_bad);
    chk("divu_stall_cyc", scyc, 32'd34);
    chk("divu_starts",    starts, 32'd1);
    chk("divu_hold_bad",  hold_bad, 32'd0);
    chk("divu_flags",     {30'd0, md_is_div, md_signed}, 32'b10);
    rd(1'b0, "divu_lo", 32'd14);
    rd(1'b1, "divu_hi", 32'd2);

    // signed div by zero is dropped
    md_hi = 32'hDEAD_0001; md_lo = 32'hDEAD_0002;
    run_md(4'b0100, 32'd55, 32'd0, 5, 0, scyc, starts, hold_bad);
    chk("div0_stall_cyc", scyc, 32'd0);
    chk("div0_starts",    starts, 32'd0);
    rd(1'b1, "div0_hi", 32'd2);
    rd(1'b0, "div0_lo", 32'd14);

    // mthi, then mflo, then mfhi
    inst_mthi = 1'b1; src_a = 32'h1234_5678;
    @(posedge clk); #1;
    inst_mthi = 1'b0; src_a = 32'd0;
    rd(1'b0, "mthi_then_mflo", 32'd14);
    rd(1'b1, "mthi_then_mfhi", 32'h1234_5678);

    // unit never answers
    md_hi = 32'hAAAA_AAAA; md_lo = 32'h5555_5555;
    run_md(4'b0010, 32'd9, 32'd9, 0, 0, scyc, starts, hold_bad);
    chk("to_stall_cyc", scyc, 32'd65);
    chk("to_flag",      {31'd0, md_timeout}, 32'd1);
    chk("to_starts",    starts, 32'd1);
    probe_idle("to_back_idle");
    rd(1'b1, "to_hi", 32'h1234_5678);
    rd(1'b0, "to_lo", 32'd14);
    chk("to_sticky", {31'd0, md_timeout}, 32'd1);

    // reset in the 2nd BUSY cycle, unit answers later
    md_hi = 32'hBEEF_0001; md_lo = 32'hBEEF_0002;
    stub_lat = 6;
    inst_mult = 1'b1; src_a = 32'd4; src_b = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; inst_mult = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstb_stallreq", {31'd0, stallreq_ex}, 32'd0);
    chk("rstb_timeout",  {31'd0, md_timeout},  32'd0);
    begin
      int late_seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (md_done) late_seen++;
        @(posedge clk); #1;
      end
      chk("rstb_late_done_seen", late_seen, 32'd1);
    end
    chk("rstb_start", {31'd0, md_start}, 32'd0);
    probe_idle("rstb_idle");
    rd(1'b1, "rstb_hi", 32'd0);
    rd(1'b0, "rstb_lo", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
